// File: rtl/axi_stream_video_rx_pkg.sv
// Shared definitions for the AXI-Stream video receiver: stream/pixel widths and FSM states.
package axi_stream_video_rx_pkg;

    localparam int AXIS_DATA_W = 16;
    localparam int PIX_W       = 10;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        WAIT_EOL = 2'd2
    } rx_state_e;

endpackage

// File: rtl/axi_stream_video_rx_pos_counter.sv
// Pixel/line position tracker. Holds the position of the next expected beat; restart forces the
// current beat to be treated as pixel 0 line 0 before inc/line_end are applied.
module axis_pos_counter
    import axi_stream_video_rx_pkg::*;
#(
    parameter int HSIZE = 1920,
    parameter int VSIZE = 3
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic inc_i,
    input  logic line_end_i,
    input  logic restart_i,
    output logic at_origin_o,
    output logic pix_last_o,
    output logic line_last_o,
    output logic wrap_o
);

    localparam int PW = (HSIZE > 1) ? $clog2(HSIZE) : 1;
    localparam int LW = (VSIZE > 1) ? $clog2(VSIZE) : 1;

    logic [PW-1:0] pix_q, pix_d, pix_eff;
    logic [LW-1:0] line_q, line_d, line_eff;

    assign pix_eff     = restart_i ? '0 : pix_q;
    assign line_eff    = restart_i ? '0 : line_q;
    assign at_origin_o = (pix_q == '0) && (line_q == '0);
    assign pix_last_o  = (pix_eff == PW'(HSIZE - 1));
    assign line_last_o = (line_eff == LW'(VSIZE - 1));
    assign wrap_o      = line_end_i & line_last_o;

    always_comb begin
        pix_d  = pix_q;
        line_d = line_q;
        if (line_end_i) begin
            pix_d  = '0;
            line_d = line_last_o ? '0 : line_eff + LW'(1);
        end else if (inc_i) begin
            // Saturate at the last pixel; the FSM handles the missing tlast.
            pix_d  = pix_last_o ? pix_eff : pix_eff + PW'(1);
            line_d = line_eff;
        end else if (restart_i) begin
            pix_d  = '0;
            line_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pix_q  <= '0;
            line_q <= '0;
        end else begin
            pix_q  <= pix_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/axi_stream_video_rx.sv
// AXI-Stream video sink: tracks pixel/line position, re-emits 10-bit pixels with SOF/EOL strobes
// and sticky framing errors. Optional per-frame checksum enabled by AXIS_RX_CHECKSUM_EN.
module axi_stream_video_rx
    import axi_stream_video_rx_pkg::*;
#(
    parameter int HSIZE = 1920,
    parameter int VSIZE = 3
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   pause_in,
    input  logic                   err_clr_in,
    input  logic                   axi_tvalid_in,
    input  logic [AXIS_DATA_W-1:0] axi_tdata_in,
    input  logic                   axi_tuser_in,
    input  logic                   axi_tlast_in,
    output logic                   axi_tready_out,
    output logic                   raw_data_valid_out,
    output logic [PIX_W-1:0]       raw_data_out,
    output logic                   sof_out,
    output logic                   eol_out,
    output logic                   frame_done_out,
    output logic [15:0]            frame_cnt_out,
    output logic                   err_early_eol_out,
    output logic                   err_late_eol_out,
    output logic                   err_sof_out,
    output logic [15:0]            checksum_out
);

    rx_state_e        state_q, state_d;
    logic             tready_q;
    logic             valid_q, valid_d, sof_q, sof_d, eol_q, eol_d, frame_done_q, frame_done_d;
    logic [PIX_W-1:0] data_q;
    logic [15:0]      frame_cnt_q;
    logic             err_early_q, err_late_q, err_sof_q;
    logic             set_early, set_late, set_sof;
    logic             accept, process, inc, line_end, restart;
    logic             at_origin, pix_last, line_last, wrap;
    logic             unused_tdata;

    assign unused_tdata = ^axi_tdata_in[AXIS_DATA_W-1:PIX_W];
    assign accept       = axi_tvalid_in & tready_q;

    axis_pos_counter #(
        .HSIZE (HSIZE),
        .VSIZE (VSIZE)
    ) u_pos (
        .clk_i       (clk_in),
        .rst_n_i     (rst_n_in),
        .inc_i       (inc),
        .line_end_i  (line_end),
        .restart_i   (restart),
        .at_origin_o (at_origin),
        .pix_last_o  (pix_last),
        .line_last_o (line_last),
        .wrap_o      (wrap)
    );

    always_comb begin
        state_d   = state_q;
        process   = 1'b0;
        inc       = 1'b0;
        line_end  = 1'b0;
        restart   = 1'b0;
        valid_d   = 1'b0;
        sof_d     = 1'b0;
        eol_d     = 1'b0;
        set_early = 1'b0;
        set_late  = 1'b0;
        set_sof   = 1'b0;
        case (state_q)
            WAIT_SOF: process = accept & axi_tuser_in;
            ACTIVE: begin
                process = accept;
                if (accept && axi_tuser_in && !at_origin) begin
                    restart = 1'b1;
                    set_sof = 1'b1;
                end
            end
            WAIT_EOL: begin
                if (accept && axi_tuser_in) begin
                    process = 1'b1;
                    restart = 1'b1;
                    set_sof = 1'b1;
                end else if (accept && axi_tlast_in) begin
                    line_end = 1'b1;
                    state_d  = line_last ? WAIT_SOF : ACTIVE;
                end
            end
            default: state_d = WAIT_SOF;
        endcase
        // Emitted beat: tuser restart has already been folded into the counter's view.
        if (process) begin
            valid_d = 1'b1;
            sof_d   = axi_tuser_in;
            if (axi_tlast_in) begin
                eol_d     = 1'b1;
                line_end  = 1'b1;
                set_early = ~pix_last;
                state_d   = line_last ? WAIT_SOF : ACTIVE;
            end else if (pix_last) begin
                set_late = 1'b1;
                state_d  = WAIT_EOL;
            end else begin
                inc     = 1'b1;
                state_d = ACTIVE;
            end
        end
        frame_done_d = wrap;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= WAIT_SOF;
            tready_q     <= 1'b0;
            valid_q      <= 1'b0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            frame_done_q <= 1'b0;
            data_q       <= '0;
            frame_cnt_q  <= '0;
            err_early_q  <= 1'b0;
            err_late_q   <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tready_q     <= ~pause_in;
            valid_q      <= valid_d;
            sof_q        <= sof_d;
            eol_q        <= eol_d;
            frame_done_q <= frame_done_d;
            if (valid_d) data_q <= axi_tdata_in[PIX_W-1:0];
            if (frame_done_d) frame_cnt_q <= frame_cnt_q + 16'd1;
            err_early_q  <= set_early | (err_early_q & ~err_clr_in);
            err_late_q   <= set_late  | (err_late_q  & ~err_clr_in);
            err_sof_q    <= set_sof   | (err_sof_q   & ~err_clr_in);
        end
    end

`ifdef AXIS_RX_CHECKSUM_EN
    logic [15:0] sum_q, sum_d, checksum_q;

    always_comb begin
        sum_d = sum_q;
        if (valid_d) sum_d = (sof_d ? 16'd0 : sum_q) + 16'(axi_tdata_in[PIX_W-1:0]);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sum_q      <= '0;
            checksum_q <= '0;
        end else begin
            sum_q <= sum_d;
            if (frame_done_d) checksum_q <= sum_d;
        end
    end

    assign checksum_out = checksum_q;
`else
    assign checksum_out = 16'd0;
`endif

    assign axi_tready_out     = tready_q;
    assign raw_data_valid_out = valid_q;
    assign raw_data_out       = data_q;
    assign sof_out            = sof_q;
    assign eol_out            = eol_q;
    assign frame_done_out     = frame_done_q;
    assign frame_cnt_out      = frame_cnt_q;
    assign err_early_eol_out  = err_early_q;
    assign err_late_eol_out   = err_late_q;
    assign err_sof_out        = err_sof_q;

endmodule

// File: tb/tb_axi_stream_video_rx.sv
// Directed bench for axi_stream_video_rx with HSIZE=8, VSIZE=3; checksum expectations follow
// AXIS_RX_CHECKSUM_EN.
module tb_axi_stream_video_rx;

    logic        clk = 1'b0, rst_n = 1'b0, pause = 1'b0, err_clr = 1'b0;
    logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0;
    logic [15:0] tdata = '0;
    logic        tready, rvalid, sof, eol, fd, e_early, e_late, e_sof;
    logic [9:0]  rdata;
    logic [15:0] fcnt, cksum;

    int n_vec = 0, n_err = 0;
    int mon_valid = 0, mon_sof = 0, mon_eol = 0, mon_fd = 0, mon_trl = 0;
    logic [9:0]  got[$];
    int          eol_at[$];
    logic [15:0] fd_cksum = '0;
    int s_valid, s_sof, s_eol, s_fd, s_trl, s_got, s_eolq, bad;
    logic [15:0] exp_ck;
    logic [9:0]  exp_pix;

    axi_stream_video_rx #(.HSIZE(8), .VSIZE(3)) dut (
        .clk_in             (clk),
        .rst_n_in           (rst_n),
        .pause_in           (pause),
        .err_clr_in         (err_clr),
        .axi_tvalid_in      (tvalid),
        .axi_tdata_in       (tdata),
        .axi_tuser_in       (tuser),
        .axi_tlast_in       (tlast),
        .axi_tready_out     (tready),
        .raw_data_valid_out (rvalid),
        .raw_data_out       (rdata),
        .sof_out            (sof),
        .eol_out            (eol),
        .frame_done_out     (fd),
        .frame_cnt_out      (fcnt),
        .err_early_eol_out  (e_early),
        .err_late_eol_out   (e_late),
        .err_sof_out        (e_sof),
        .checksum_out       (cksum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rvalid) begin
            if (eol) eol_at.push_back(got.size());
            got.push_back(rdata);
            mon_valid++;
            if (sof) mon_sof++;
            if (eol) mon_eol++;
        end
        if (fd) begin
            mon_fd++;
            fd_cksum = cksum;
        end
        if (!tready && rst_n) mon_trl++;
    end

    task automatic mark();
        s_valid = mon_valid; s_sof = mon_sof; s_eol = mon_eol; s_fd = mon_fd; s_trl = mon_trl;
        s_got = got.size(); s_eolq = eol_at.size();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [9:0] pix, input logic u, input logic l);
        int guard;
        guard = 0;
        tvalid = 1'b1; tdata = {~pix[5:0], pix}; tuser = u; tlast = l;
        @(negedge clk);
        while (tready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) begin
            n_vec++; n_err++;
            $display("FAIL send_beat.tready_timeout got tready=%b required 1", tready);
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < 24; i++) send_beat(10'(base + i), i == 0, (i % 8) == 7);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle(3);
        n_vec++; if (tready !== 1'b0) begin n_err++; $display("FAIL reset.tready got %b required 0", tready); end
        n_vec++; if ({rvalid, sof, eol, fd} !== 4'b0) begin n_err++; $display("FAIL reset.strobes got %b required 0000", {rvalid, sof, eol, fd}); end
        n_vec++; if (fcnt !== 16'd0 || rdata !== 10'd0) begin n_err++; $display("FAIL reset.cnt_data got fcnt=%0d data=%0d required 0 0", fcnt, rdata); end
        n_vec++; if ({e_early, e_late, e_sof} !== 3'b0 || cksum !== 16'd0) begin n_err++; $display("FAIL reset.errs got %b cksum=%0d required 000 0", {e_early, e_late, e_sof}, cksum); end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (tready !== 1'b0) begin n_err++; $display("FAIL reset.tready_delay got %b required 0", tready); end
        idle(1);
        n_vec++; if (tready !== 1'b1) begin n_err++; $display("FAIL reset.tready_release got %b required 1", tready); end
        $display("test_reset: reset released, tready=%b", tready);
    endtask

    task automatic test_clean_frame();
        mark();
        for (int i = 0; i < 24; i++) begin
            send_beat(10'(i), i == 0, (i % 8) == 7);
            if (i == 0) begin
                n_vec++; if ({rvalid, sof, rdata} !== {2'b11, 10'd0}) begin n_err++; $display("FAIL clean.first_latency got v=%b sof=%b d=%0d required 1 1 0", rvalid, sof, rdata); end
            end
        end
        idle(3);
        n_vec++; if (mon_valid - s_valid !== 24) begin n_err++; $display("FAIL clean.valids got %0d required 24", mon_valid - s_valid); end
        n_vec++; if (mon_sof - s_sof !== 1 || mon_eol - s_eol !== 3) begin n_err++; $display("FAIL clean.sof_eol got %0d/%0d required 1/3", mon_sof - s_sof, mon_eol - s_eol); end
        n_vec++; if (mon_fd - s_fd !== 1 || fcnt !== 16'd1) begin n_err++; $display("FAIL clean.frame got fd=%0d cnt=%0d required 1 1", mon_fd - s_fd, fcnt); end
        bad = 0;
        for (int i = 0; i < 24; i++) if (got[s_got + i] !== 10'(i)) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL clean.data got %0d wrong pixels required 0", bad); end
        n_vec++; if (eol_at[s_eolq] - s_got !== 7 || eol_at[s_eolq + 1] - s_got !== 15 || eol_at[s_eolq + 2] - s_got !== 23) begin n_err++; $display("FAIL clean.eol_pos got %0d,%0d,%0d required 7,15,23", eol_at[s_eolq] - s_got, eol_at[s_eolq + 1] - s_got, eol_at[s_eolq + 2] - s_got); end
        n_vec++; if ({e_early, e_late, e_sof} !== 3'b0) begin n_err++; $display("FAIL clean.errs got %b required 000", {e_early, e_late, e_sof}); end
`ifdef AXIS_RX_CHECKSUM_EN
        exp_ck = 16'd276;
`else
        exp_ck = 16'd0;
`endif
        n_vec++; if (fd_cksum !== exp_ck || cksum !== exp_ck) begin n_err++; $display("FAIL clean.checksum got %0d/%0d required %0d", fd_cksum, cksum, exp_ck); end
        $display("test_clean_frame: 24 beats, frame_cnt=%0d checksum=%0d", fcnt, cksum);
    endtask

    task automatic test_junk_before_sof();
        mark();
        for (int i = 0; i < 5; i++) send_beat(10'(500 + i), 1'b0, i == 2);
        send_frame(0);
        idle(3);
        n_vec++; if (mon_valid - s_valid !== 24 || mon_sof - s_sof !== 1 || mon_eol - s_eol !== 3) begin n_err++; $display("FAIL junk.counts got v=%0d sof=%0d eol=%0d required 24 1 3", mon_valid - s_valid, mon_sof - s_sof, mon_eol - s_eol); end
        bad = 0;
        for (int i = 0; i < 24; i++) if (got[s_got + i] !== 10'(i)) bad++;
        n_vec++; if (bad != 0 || fcnt !== 16'd2) begin n_err++; $display("FAIL junk.data got bad=%0d fcnt=%0d required 0 2", bad, fcnt); end
        n_vec++; if ({e_early, e_late, e_sof} !== 3'b0) begin n_err++; $display("FAIL junk.errs got %b required 000", {e_early, e_late, e_sof}); end
        $display("test_junk_before_sof: 5 junk + 24 beats, frame_cnt=%0d", fcnt);
    endtask

    task automatic test_early_eol();
        mark();
        for (int k = 0; k < 22; k++) send_beat(10'(k), k == 0, k == 7 || k == 13 || k == 21);
        idle(3);
        n_vec++; if (mon_valid - s_valid !== 22 || mon_eol - s_eol !== 3 || mon_fd - s_fd !== 1) begin n_err++; $display("FAIL early.counts got v=%0d eol=%0d fd=%0d required 22 3 1", mon_valid - s_valid, mon_eol - s_eol, mon_fd - s_fd); end
        n_vec++; if (eol_at[s_eolq + 1] - s_got !== 13 || eol_at[s_eolq + 2] - s_got !== 21) begin n_err++; $display("FAIL early.eol_pos got %0d,%0d required 13,21", eol_at[s_eolq + 1] - s_got, eol_at[s_eolq + 2] - s_got); end
        n_vec++; if ({e_early, e_late, e_sof} !== 3'b100 || fcnt !== 16'd3) begin n_err++; $display("FAIL early.errs got %b fcnt=%0d required 100 3", {e_early, e_late, e_sof}, fcnt); end
`ifdef AXIS_RX_CHECKSUM_EN
        exp_ck = 16'd231;
`else
        exp_ck = 16'd0;
`endif
        n_vec++; if (cksum !== exp_ck) begin n_err++; $display("FAIL early.checksum got %0d required %0d", cksum, exp_ck); end
        pulse_err_clr();
        n_vec++; if (e_early !== 1'b0) begin n_err++; $display("FAIL early.clear got %b required 0", e_early); end
        $display("test_early_eol: 22 beats, err_early flagged then cleared, frame_cnt=%0d", fcnt);
    endtask

    task automatic test_late_eol();
        mark();
        for (int k = 0; k < 26; k++) send_beat(10'(k), k == 0, k == 9 || k == 17 || k == 25);
        idle(3);
        n_vec++; if (mon_valid - s_valid !== 24 || mon_eol - s_eol !== 2 || mon_fd - s_fd !== 1) begin n_err++; $display("FAIL late.counts got v=%0d eol=%0d fd=%0d required 24 2 1", mon_valid - s_valid, mon_eol - s_eol, mon_fd - s_fd); end
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            exp_pix = (i < 8) ? 10'(i) : 10'(i + 2);
            if (got[s_got + i] !== exp_pix) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL late.data got %0d wrong pixels required 0", bad); end
        n_vec++; if (eol_at[s_eolq] - s_got !== 15 || eol_at[s_eolq + 1] - s_got !== 23) begin n_err++; $display("FAIL late.eol_pos got %0d,%0d required 15,23", eol_at[s_eolq] - s_got, eol_at[s_eolq + 1] - s_got); end
        n_vec++; if ({e_early, e_late, e_sof} !== 3'b010 || fcnt !== 16'd4) begin n_err++; $display("FAIL late.errs got %b fcnt=%0d required 010 4", {e_early, e_late, e_sof}, fcnt); end
`ifdef AXIS_RX_CHECKSUM_EN
        exp_ck = 16'd308;
`else
        exp_ck = 16'd0;
`endif
        n_vec++; if (cksum !== exp_ck) begin n_err++; $display("FAIL late.checksum got %0d required %0d", cksum, exp_ck); end
        pulse_err_clr();
        $display("test_late_eol: 26 beats, 2 dropped, frame_cnt=%0d", fcnt);
    endtask

    task automatic test_pause();
        mark();
        fork
            send_frame(0);
            begin
                idle(3);
                pause = 1'b1;
                @(negedge clk);
                n_vec++; if (tready !== 1'b1) begin n_err++; $display("FAIL pause.delay got tready=%b required 1", tready); end
                repeat (4) @(posedge clk);
                #1;
                pause = 1'b0;
            end
        join
        idle(3);
        n_vec++; if (mon_trl - s_trl !== 4) begin n_err++; $display("FAIL pause.tready_low got %0d cycles required 4", mon_trl - s_trl); end
        bad = 0;
        for (int i = 0; i < 24; i++) if (got[s_got + i] !== 10'(i)) bad++;
        n_vec++; if (mon_valid - s_valid !== 24 || bad != 0 || fcnt !== 16'd5) begin n_err++; $display("FAIL pause.data got v=%0d bad=%0d fcnt=%0d required 24 0 5", mon_valid - s_valid, bad, fcnt); end
        $display("test_pause: 4-cycle backpressure, frame_cnt=%0d", fcnt);
    endtask

    task automatic test_sof_restart();
        mark();
        for (int k = 0; k < 3; k++) send_beat(10'(100 + k), k == 0, 1'b0);
        send_frame(0);
        idle(3);
        n_vec++; if (mon_valid - s_valid !== 27 || mon_sof - s_sof !== 2 || mon_fd - s_fd !== 1) begin n_err++; $display("FAIL sof.counts got v=%0d sof=%0d fd=%0d required 27 2 1", mon_valid - s_valid, mon_sof - s_sof, mon_fd - s_fd); end
        n_vec++; if (eol_at[s_eolq] - s_got !== 10 || eol_at[s_eolq + 2] - s_got !== 26) begin n_err++; $display("FAIL sof.eol_pos got %0d,%0d required 10,26", eol_at[s_eolq] - s_got, eol_at[s_eolq + 2] - s_got); end
        n_vec++; if ({e_early, e_late, e_sof} !== 3'b001 || fcnt !== 16'd6) begin n_err++; $display("FAIL sof.errs got %b fcnt=%0d required 001 6", {e_early, e_late, e_sof}, fcnt); end
`ifdef AXIS_RX_CHECKSUM_EN
        exp_ck = 16'd276;
`else
        exp_ck = 16'd0;
`endif
        n_vec++; if (cksum !== exp_ck) begin n_err++; $display("FAIL sof.checksum got %0d required %0d", cksum, exp_ck); end
        $display("test_sof_restart: stray tuser at pixel 3, frame_cnt=%0d", fcnt);
    endtask

    task automatic test_err_clear();
        pulse_err_clr();
        n_vec++; if ({e_early, e_late, e_sof} !== 3'b000) begin n_err++; $display("FAIL clr.all got %b required 000", {e_early, e_late, e_sof}); end
        for (int k = 0; k < 3; k++) send_beat(10'(200 + k), k == 0, 1'b0);
        err_clr = 1'b1;
        send_beat(10'd203, 1'b1, 1'b0);
        n_vec++; if (e_sof !== 1'b1) begin n_err++; $display("FAIL clr.set_priority got %b required 1", e_sof); end
        idle(1);
        n_vec++; if (e_sof !== 1'b0) begin n_err++; $display("FAIL clr.after got %b required 0", e_sof); end
        err_clr = 1'b0;
        $display("test_err_clear: flags cleared, set beats clear");
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 4; k++) send_beat(10'(k), k == 0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_vec++; if ({rvalid, tready} !== 2'b00 || fcnt !== 16'd0) begin n_err++; $display("FAIL areset.outs got v=%b rdy=%b fcnt=%0d required 0 0 0", rvalid, tready, fcnt); end
        idle(2);
        rst_n = 1'b1;
        idle(2);
        mark();
        for (int k = 0; k < 2; k++) send_beat(10'(300 + k), 1'b0, 1'b0);
        send_frame(0);
        idle(3);
        n_vec++; if (mon_valid - s_valid !== 24 || mon_fd - s_fd !== 1 || fcnt !== 16'd1) begin n_err++; $display("FAIL areset.resume got v=%0d fd=%0d fcnt=%0d required 24 1 1", mon_valid - s_valid, mon_fd - s_fd, fcnt); end
        $display("test_async_reset: mid-frame reset, resumed frame_cnt=%0d", fcnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog.timeout got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clean_frame();
        test_junk_before_sof();
        test_early_eol();
        test_late_eol();
        test_pause();
        test_sof_restart();
        test_err_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
